// File: rtl/scope_pkg.sv
// scope_pkg: shared state encoding, default parameters and threshold helper for trigger_capture.
package scope_pkg;
   typedef enum logic [2:0] {IDLE, PRE, ARMED, POST, DONE} state_t;
   localparam int ADDR_W_DEF   = 10;
   localparam int PRE_TRIG_DEF = 256;
   localparam int AUTO_TO_DEF  = 65535;
   // Hysteresis re-arm threshold: level+hyst (up=1) or level-hyst (up=0), saturated to 0..255.
   function automatic logic [7:0] arm_thresh(input logic [7:0] level, input logic [3:0] hyst, input logic up);
      logic [8:0] lo;
      logic [8:0] hi;
      lo = {1'b0, level} - {5'd0, hyst};
      hi = {1'b0, level} + {5'd0, hyst};
      return up ? (hi[8] ? 8'hff : hi[7:0]) : (lo[8] ? 8'h00 : lo[7:0]);
   endfunction
endpackage

// File: rtl/trig_detect.sv
// trig_detect: slope/hysteresis comparator for one sample.
//   sample, level   : current sample and trigger threshold
//   slope           : 0 rising, 1 falling
//   hyst            : hysteresis in LSBs
//   flag            : current hysteresis flag (held by the caller)
//   set_flag        : sample has moved far enough away to re-arm the flag
//   fire            : flag is armed and the sample crosses the level
module trig_detect
   import scope_pkg::*;
(
   input  logic [7:0] sample,
   input  logic [7:0] level,
   input  logic       slope,
   input  logic [3:0] hyst,
   input  logic       flag,
   output logic       set_flag,
   output logic       fire
);
   assign set_flag = slope ? (sample >= arm_thresh(level, hyst, 1'b1))
                           : (sample <= arm_thresh(level, hyst, 1'b0));
   assign fire     = flag & (slope ? (sample <= level) : (sample >= level));
endmodule

// File: rtl/trigger_capture.sv
// trigger_capture: pre/post-trigger sample capture into a circular buffer.
//   clk, rst_n                 : clock, asynchronous active-low reset
//   adc_data, adc_valid        : offset-binary sample stream
//   trig_level/slope/hyst      : trigger comparator setup (latched at arm)
//   decim                      : keep 1 of every decim+1 valid samples (latched at arm)
//   auto_mode                  : force a trigger after AUTO_TO armed samples
//   arm                        : start a capture (only honoured in IDLE)
//   wr_en, wr_addr, wr_data    : buffer write port
//   trig_addr                  : buffer address of the trigger sample
//   frame_done, busy           : completion pulse, capture in progress
module trigger_capture
   import scope_pkg::*;
#(
   parameter int ADDR_W   = ADDR_W_DEF,
   parameter int PRE_TRIG = PRE_TRIG_DEF,
   parameter int AUTO_TO  = AUTO_TO_DEF
)(
   input  logic              clk,
   input  logic              rst_n,
   input  logic [7:0]        adc_data,
   input  logic              adc_valid,
   input  logic [7:0]        trig_level,
   input  logic              trig_slope,
   input  logic [3:0]        hyst,
   input  logic [3:0]        decim,
   input  logic              auto_mode,
   input  logic              arm,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [7:0]        wr_data,
   output logic [ADDR_W-1:0] trig_addr,
   output logic              frame_done,
   output logic              busy
);
   localparam int DEPTH  = 2 ** ADDR_W;
   localparam int POST_N = DEPTH - PRE_TRIG - 1;
   localparam int TO_W   = $clog2(AUTO_TO + 1);
   state_t            state;
   logic [ADDR_W-1:0] ptr;
   logic [ADDR_W-1:0] pre_cnt;
   logic [ADDR_W-1:0] post_cnt;
   logic [3:0]        dec_cnt;
   logic [TO_W-1:0]   auto_cnt;
   logic              flag;
   logic [7:0]        level_r;
   logic              slope_r;
   logic [3:0]        hyst_r;
   logic [3:0]        decim_r;
   logic              capturing;
   logic              accept;
   logic              set_flag;
   logic              fire;
   logic              auto_fire;
   assign capturing = state inside {PRE, ARMED, POST};
   assign accept    = adc_valid && dec_cnt == 4'd0;
   // Auto counter saturates at AUTO_TO-1 so the forced trigger lands on the AUTO_TO-th sample.
   assign auto_fire = auto_mode && auto_cnt == TO_W'(AUTO_TO - 1);
   trig_detect u_det (
      .sample   (adc_data),
      .level    (level_r),
      .slope    (slope_r),
      .hyst     (hyst_r),
      .flag     (flag),
      .set_flag (set_flag),
      .fire     (fire)
   );
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         wr_en      <= 1'b0;
         wr_addr    <= '0;
         wr_data    <= '0;
         trig_addr  <= '0;
         frame_done <= 1'b0;
         busy       <= 1'b0;
         ptr        <= '0;
         pre_cnt    <= '0;
         post_cnt   <= '0;
         dec_cnt    <= '0;
         auto_cnt   <= '0;
         flag       <= 1'b0;
         level_r    <= '0;
         slope_r    <= 1'b0;
         hyst_r     <= '0;
         decim_r    <= '0;
      end else begin
         wr_en      <= 1'b0;
         frame_done <= 1'b0;
         if (capturing && adc_valid) dec_cnt <= (dec_cnt == decim_r) ? 4'd0 : dec_cnt + 4'd1;
         if (capturing && accept) begin
            wr_en   <= 1'b1;
            wr_data <= adc_data;
            wr_addr <= ptr;
            ptr     <= ptr + ADDR_W'(1);
         end
         case (state)
            IDLE: if (arm) begin
               state   <= PRE;
               busy    <= 1'b1;
               ptr     <= '0;
               dec_cnt <= '0;
               pre_cnt <= '0;
               flag    <= 1'b0;
               level_r <= trig_level;
               slope_r <= trig_slope;
               hyst_r  <= hyst;
               decim_r <= decim;
            end
            PRE: if (accept) begin
               pre_cnt <= pre_cnt + ADDR_W'(1);
               if (pre_cnt == ADDR_W'(PRE_TRIG - 1)) begin
                  state    <= ARMED;
                  auto_cnt <= '0;
               end
            end
            ARMED: if (accept) begin
               if (fire || auto_fire) begin
                  trig_addr  <= ptr;
                  post_cnt   <= '0;
                  state      <= (POST_N == 0) ? DONE : POST;
                  frame_done <= (POST_N == 0);
               end else begin
                  if (set_flag) flag <= 1'b1;
                  if (auto_cnt != TO_W'(AUTO_TO - 1)) auto_cnt <= auto_cnt + TO_W'(1);
               end
            end
            POST: if (accept) begin
               post_cnt <= post_cnt + ADDR_W'(1);
               if (post_cnt == ADDR_W'(POST_N - 1)) begin
                  state      <= DONE;
                  frame_done <= 1'b1;
               end
            end
            DONE: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_trigger_capture.sv
// tb_trigger_capture: directed and random captures checked against a sample-list reference model.
module tb_trigger_capture;
   localparam int AW    = 6;
   localparam int DEPTH = 64;
   localparam int P     = 16;
   localparam int ATO   = 16;

   logic          clk = 1'b0;
   logic          rst_n = 1'b1;
   logic [7:0]    adc_data = '0;
   logic          adc_valid = 1'b0;
   logic [7:0]    trig_level = '0;
   logic          trig_slope = 1'b0;
   logic [3:0]    hyst = '0;
   logic [3:0]    decim = '0;
   logic          auto_mode = 1'b0;
   logic          arm = 1'b0;
   logic          wr_en;
   logic [AW-1:0] wr_addr;
   logic [7:0]    wr_data;
   logic [AW-1:0] trig_addr;
   logic          frame_done;
   logic          busy;

   trigger_capture #(.ADDR_W(AW), .PRE_TRIG(P), .AUTO_TO(ATO)) dut (
      .clk(clk), .rst_n(rst_n), .adc_data(adc_data), .adc_valid(adc_valid),
      .trig_level(trig_level), .trig_slope(trig_slope), .hyst(hyst), .decim(decim),
      .auto_mode(auto_mode), .arm(arm), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .trig_addr(trig_addr), .frame_done(frame_done), .busy(busy)
   );

   always #5 clk = ~clk;

   int            n_assert = 0;
   int            n_fail = 0;
   logic [9:0]    stim[$];
   logic [7:0]    obs_d[$];
   logic [AW-1:0] obs_a[$];
   int            fd_count;
   int            fd_at;
   logic [7:0]    exp_d[$];
   int            exp_ti;
   int            exp_n;
   bit            exp_done;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference: list of accepted samples, first P pre-trigger, scan for trigger, then DEPTH-P-1 more.
   task automatic model(input int lvl, input bit sl, input int hy, input int dc, input bit au);
      automatic logic [7:0] acc[$];
      automatic int vc = 0;
      automatic int lo = (lvl > hy) ? lvl - hy : 0;
      automatic int hi = (lvl + hy > 255) ? 255 : lvl + hy;
      automatic bit flag = 0;
      foreach (stim[i]) if (stim[i][8]) begin
         if (vc % (dc + 1) == 0) acc.push_back(stim[i][7:0]);
         vc++;
      end
      exp_ti = -1;
      for (int i = P; i < acc.size(); i++) begin
         automatic int s = acc[i];
         if ((flag && (sl ? s <= lvl : s >= lvl)) || (au && i - P + 1 >= ATO)) begin
            exp_ti = i;
            break;
         end
         if (sl ? s >= hi : s <= lo) flag = 1;
      end
      exp_done = exp_ti >= 0 && acc.size() >= exp_ti + DEPTH - P;
      exp_n = exp_done ? exp_ti + DEPTH - P : acc.size();
      exp_d.delete();
      for (int i = 0; i < exp_n; i++) exp_d.push_back(acc[i]);
   endtask

   task automatic sample_out();
      if (wr_en) begin
         obs_d.push_back(wr_data);
         obs_a.push_back(wr_addr);
      end
      if (frame_done) begin
         fd_count++;
         fd_at = obs_d.size();
      end
   endtask

   task automatic pulse_reset();
      #2 rst_n = 1'b0;
      #1;
      chk("rst_wr_en", wr_en, 0);
      chk("rst_busy", busy, 0);
      chk("rst_frame_done", frame_done, 0);
      chk("rst_wr_addr", wr_addr, 0);
      chk("rst_wr_data", wr_data, 0);
      chk("rst_trig_addr", trig_addr, 0);
   endtask

   // abort_post >= 0: assert reset that many writes after the trigger write.
   task automatic run(input logic [7:0] lvl, input bit sl, input logic [3:0] hy,
                      input logic [3:0] dc, input bit au, input int abort_post);
      model(lvl, sl, hy, dc, au);
      trig_level = lvl; trig_slope = sl; hyst = hy; decim = dc; auto_mode = au;
      arm = 1'b1; adc_valid = 1'b0;
      @(posedge clk); #1;
      chk("busy_after_arm", busy, 1);
      arm = 1'b0;
      trig_level = 8'($urandom); trig_slope = 1'($urandom); hyst = 4'($urandom); decim = 4'($urandom);
      obs_d.delete(); obs_a.delete(); fd_count = 0; fd_at = -1;
      foreach (stim[i]) begin
         {arm, adc_valid, adc_data} = stim[i];
         @(posedge clk); #1;
         sample_out();
         if (abort_post >= 0 && obs_d.size() >= exp_ti + 1 + abort_post) begin
            pulse_reset();
            arm = 1'b0;
            repeat (3) begin
               @(posedge clk); #1;
               chk("abort_no_frame_done", frame_done, 0);
               chk("abort_idle_busy", busy, 0);
            end
            rst_n = 1'b1;
            return;
         end
      end
      arm = 1'b0; adc_valid = 1'b0;
      repeat (3) begin
         @(posedge clk); #1;
         sample_out();
      end
      chk("n_writes", obs_d.size(), exp_n);
      for (int i = 0; i < obs_d.size() && i < exp_n; i++) begin
         chk("wr_addr", obs_a[i], i % DEPTH);
         chk("wr_data", obs_d[i], exp_d[i]);
      end
      chk("frame_done_count", fd_count, exp_done);
      if (exp_done) begin
         chk("frame_done_at_write", fd_at, exp_n);
         chk("trig_addr", trig_addr, exp_ti % DEPTH);
         chk("busy_after_done", busy, 0);
      end else begin
         pulse_reset();
         rst_n = 1'b1;
      end
   endtask

   // The trigger write sits DEPTH-P writes before the end of the final frame.
   task automatic trig_sample(input string tag, input logic [7:0] v, input bit chk_prev, input logic [7:0] pv);
      automatic int k = obs_d.size() - (DEPTH - P);
      chk({tag, "_frame_len"}, k >= 1, 1);
      if (k >= 1) begin
         chk({tag, "_addr"}, obs_a[k], trig_addr);
         chk({tag, "_data"}, obs_d[k], v);
         if (chk_prev) chk({tag, "_prev"}, obs_d[k-1], pv);
      end
   endtask

   initial begin
      #2 rst_n = 1'b0;
      #1;
      chk("init_wr_en", wr_en, 0);
      chk("init_busy", busy, 0);
      chk("init_frame_done", frame_done, 0);
      chk("init_wr_addr", wr_addr, 0);
      chk("init_trig_addr", trig_addr, 0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk); #1;

      stim.delete();
      for (int i = 0; i < 600; i++) stim.push_back({2'b01, 8'(i)});
      run(8'd128, 1'b0, 4'd4, 4'd0, 1'b0, -1);
      trig_sample("ramp", 8'd128, 1'b1, 8'd127);

      stim.delete();
      for (int i = 0; i < 200; i++) stim.push_back({2'b01, ((i / 4) % 2) ? 8'd0 : 8'd255});
      run(8'd100, 1'b1, 4'd4, 4'd0, 1'b0, -1);
      trig_sample("square", 8'd0, 1'b1, 8'd255);

      stim.delete();
      for (int i = 0; i < 120; i++) stim.push_back({2'b01, 8'd50});
      run(8'd128, 1'b0, 4'd4, 4'd0, 1'b1, -1);
      chk("auto_trig_addr", trig_addr, P + ATO - 1);
      trig_sample("auto", 8'd50, 1'b0, 8'd0);

      stim.delete();
      for (int i = 0; i < 1600; i++) stim.push_back({1'b0, 1'($urandom), 8'($urandom)});
      run(8'd128, 1'b0, 4'd0, 4'd3, 1'b0, -1);

      stim.delete();
      for (int i = 0; i < 300; i++) stim.push_back({2'b01, 8'(126 + $urandom_range(0, 4))});
      for (int i = 0; i < 10; i++) stim.push_back({2'b01, 8'd108});
      for (int i = 0; i < 26; i++) stim.push_back({2'b01, 8'(110 + 2 * i)});
      for (int i = 0; i < 100; i++) stim.push_back({2'b01, 8'd150});
      run(8'd128, 1'b0, 4'd4, 4'd0, 1'b0, -1);
      trig_sample("noise_dip", 8'd128, 1'b1, 8'd126);

      for (int k = 0; k < 3; k++) begin
         stim.delete();
         for (int i = 0; i < 1200; i++)
            stim.push_back({1'(i == 3 || i == 7), 1'($urandom_range(0, 3) != 0), 8'($urandom)});
         run(8'($urandom_range(40, 215)), 1'($urandom), 4'($urandom), 4'($urandom_range(0, 2)), k == 2, -1);
      end

      stim.delete();
      for (int i = 0; i < 600; i++) stim.push_back({2'b01, 8'(i)});
      run(8'd128, 1'b0, 4'd4, 4'd0, 1'b0, 5);
      run(8'd128, 1'b0, 4'd4, 4'd0, 1'b0, -1);
      trig_sample("rearm", 8'd128, 1'b1, 8'd127);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end
endmodule
